// File: rtl/life_pkg.sv
// Shared types for the Game-of-life display pipeline: controller states,
// vsync polarity constants and the bank-select type.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    WAIT_VB
  } life_state_e;

  localparam bit VSPP_NEG = 1'b0;
  localparam bit VSPP_POS = 1'b1;

  typedef logic bank_sel_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Vsync edge detector: one-cycle tick on the inactive-to-active transition
// of vsync, for the given active polarity.
module frame_tick_gen #(
  parameter bit VSPP = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;

  // NOTE: registered state is always assigned with <=, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_q <= !VSPP;
    else        vsync_q <= vsync;
  end

  assign tick = (vsync == VSPP) && (vsync_q != VSPP);

endmodule

// File: rtl/life_frame_ctrl.sv
// Ping-pong generation controller: paces the evolution engine per frame and
// swaps the displayed bank only at a vsync boundary.
module life_frame_ctrl
  import life_pkg::*;
#(
  parameter bit VSPP    = VSPP_NEG,
  parameter int SPEED_W = 4,
  parameter int GEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               run,
  input  logic               step,
  input  logic [SPEED_W-1:0] speed,
  output logic               gen_start,
  input  logic               gen_done,
  input  logic               edit_req,
  output logic               edit_ack,
  output bank_sel_t          disp_bank,
  output logic               busy,
  output logic [GEN_W-1:0]   gen_count
);

  life_state_e        state;
  logic [SPEED_W-1:0] frame_cnt;
  logic [SPEED_W-1:0] frame_cnt_inc;
  logic               step_pending;
  logic               frame_tick;
  logic               launch;

  frame_tick_gen #(.VSPP(VSPP)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .vsync (vsync),
    .tick  (frame_tick)
  );

  assign frame_cnt_inc = (&frame_cnt) ? frame_cnt : frame_cnt + SPEED_W'(1);
  // >= rather than == so a speed lowered mid-wait fires on the very next tick
  assign launch = frame_tick && (step_pending || (run && frame_cnt >= speed));

  // Gated by rst_n so the ack reads low while reset is held, even with edit_req up
  assign edit_ack = rst_n && edit_req && (state == IDLE) && !frame_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      step_pending <= 1'b0;
      disp_bank    <= 1'b0;
      gen_count    <= '0;
      gen_start    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      gen_start <= 1'b0;

      // A step landing in START survives the clear and drives the next generation
      if (step)                 step_pending <= 1'b1;
      else if (state == START)  step_pending <= 1'b0;

      unique case (state)
        IDLE: begin
          if (launch) begin
            state     <= START;
            gen_start <= 1'b1;
            busy      <= 1'b1;
            frame_cnt <= '0;
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt_inc;
          end
        end
        START: begin
          state <= RUN;
          if (frame_tick) frame_cnt <= frame_cnt_inc;
        end
        RUN: begin
          if (frame_tick) frame_cnt <= frame_cnt_inc;
          if (gen_done)   state     <= WAIT_VB;
        end
        WAIT_VB: begin
          // Swap only on a tick seen after completion, never the one coinciding with gen_done
          if (frame_tick) begin
            disp_bank <= ~disp_bank;
            gen_count <= gen_count + GEN_W'(1);
            frame_cnt <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_frame_ctrl.sv
// Scoreboard bench for life_frame_ctrl: directed scenarios push expected
// gen_start/swap events; a negedge monitor pops and compares them.
module tb_life_frame_ctrl;
  import life_pkg::*;

  localparam int SPEED_W = 4;
  localparam int GEN_W   = 16;
  localparam int FP      = 200;
  localparam int ACT     = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vsync = 1'b1;
  logic               run;
  logic               step;
  logic [SPEED_W-1:0] speed;
  logic               gen_start;
  logic               gen_done = 1'b0;
  logic               edit_req;
  logic               edit_ack;
  bank_sel_t          disp_bank;
  logic               busy;
  logic [GEN_W-1:0]   gen_count;

  typedef enum int {EV_START, EV_SWAP} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       tick;
    logic     bank;
    int       gen;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  tick_n = 0;
  int  last_tick_cyc = 0;
  int  eng_lat = 100;

  life_frame_ctrl #(.VSPP(VSPP_NEG), .SPEED_W(SPEED_W), .GEN_W(GEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .run       (run),
    .step      (step),
    .speed     (speed),
    .gen_start (gen_start),
    .gen_done  (gen_done),
    .edit_req  (edit_req),
    .edit_ack  (edit_ack),
    .disp_bank (disp_bank),
    .busy      (busy),
    .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(ev_kind_e k, int t, logic b, int g);
    ev_t e;
    e.kind = k;
    e.tick = t;
    e.bank = b;
    e.gen  = g;
    exp_q.push_back(e);
  endtask

  task automatic observe(ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s at tick %0d expected none", k.name(), tick_n);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", k, e.kind);
      check("ev_tick", tick_n, e.tick);
      check("ev_latency", cyc - last_tick_cyc, 1);
      check("ev_bank", disp_bank, e.bank);
      check("ev_gen", gen_count, e.gen);
    end
  endtask

  task automatic wait_tick_exact(int id);
    while (tick_n < id) @(negedge clk);
  endtask

  task automatic settle_after(int id);
    wait_tick_exact(id);
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Free-running vsync: active for ACT cycles at the start of every FP-cycle frame
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      vsync = ((cyc % FP) < ACT) ? VSPP_NEG : ~VSPP_NEG;
      if ((cyc % FP) == 0) begin
        tick_n++;
        last_tick_cyc = cyc;
      end
    end
  end

  // Engine model: gen_done eng_lat cycles after each observed gen_start
  initial begin
    forever begin
      @(negedge clk);
      if (gen_start) begin
        repeat (eng_lat) @(posedge clk);
        #1 gen_done = 1'b1;
        @(posedge clk);
        #1 gen_done = 1'b0;
      end
    end
  end

  initial begin
    logic prev_bank;
    prev_bank = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_bank = 1'b0;
      end else begin
        if (gen_start) observe(EV_START);
        if (disp_bank !== prev_bank) observe(EV_SWAP);
        prev_bank = disp_bank;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout at cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, c, d, e, f;
    rst_n    = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    speed    = '0;
    edit_req = 1'b1;

    // Reset held while vsync toggles
    repeat (3) @(negedge clk);
    check("rst_disp_bank", disp_bank, 0);
    check("rst_gen_count", gen_count, 0);
    check("rst_gen_start", gen_start, 0);
    check("rst_busy", busy, 0);
    check("rst_edit_ack", edit_ack, 0);
    settle_after(2);
    check("rst_hold_gen_start", gen_start, 0);
    rst_n = 1'b1;

    // Idle with run=0: edit_ack masked only on the tick cycle, no generations
    wait_tick_exact(4);
    check("edit_ack_on_tick", edit_ack, 0);
    @(negedge clk);
    check("edit_ack_idle", edit_ack, 1);
    settle_after(5);
    check("idle_busy", busy, 0);
    check("idle_disp_bank", disp_bank, 0);
    check("idle_gen_count", gen_count, 0);
    b = tick_n;

    // run=1, speed=0: a generation every two frames
    expect_ev(EV_START, b + 1, 1'b0, 0);
    expect_ev(EV_SWAP,  b + 2, 1'b1, 1);
    expect_ev(EV_START, b + 3, 1'b1, 1);
    expect_ev(EV_SWAP,  b + 4, 1'b0, 2);
    run = 1'b1;
    settle_after(b + 4);
    run = 1'b0;
    settle_after(b + 6);
    check("free_gen_count", gen_count, 2);
    c = tick_n;

    // speed=3: frame_cnt is 2 here, so the first start is two ticks out,
    // then four ticks lie between consecutive starts
    expect_ev(EV_START, c + 2, 1'b0, 2);
    expect_ev(EV_SWAP,  c + 3, 1'b1, 3);
    expect_ev(EV_START, c + 7, 1'b1, 3);
    expect_ev(EV_SWAP,  c + 8, 1'b0, 4);
    speed = 4'd3;
    run   = 1'b1;
    settle_after(c + 10);
    // frame_cnt is 2; lowering speed to 1 fires on the next compare
    expect_ev(EV_START, c + 11, 1'b0, 4);
    expect_ev(EV_SWAP,  c + 12, 1'b1, 5);
    speed = 4'd1;
    settle_after(c + 11);
    run = 1'b0;
    settle_after(c + 12);
    d = tick_n;

    // Single step while paused
    expect_ev(EV_START, d + 1, 1'b1, 5);
    expect_ev(EV_SWAP,  d + 2, 1'b0, 6);
    pulse_step();
    settle_after(d + 4);
    check("step_busy", busy, 0);
    e = tick_n;

    // gen_done coincides with a tick in RUN: swap deferred one frame
    eng_lat = FP - 1;
    expect_ev(EV_START, e + 1, 1'b0, 6);
    expect_ev(EV_SWAP,  e + 3, 1'b1, 7);
    pulse_step();
    wait_tick_exact(e + 1);
    check("coin_ack_tick", edit_ack, 0);
    @(negedge clk);
    check("coin_ack_start", edit_ack, 0);
    check("coin_busy_start", busy, 1);
    repeat (50) @(negedge clk);
    check("coin_ack_run", edit_ack, 0);
    wait_tick_exact(e + 2);
    @(negedge clk);
    check("coin_no_swap", disp_bank, 0);
    check("coin_busy_wait", busy, 1);
    check("coin_ack_wait", edit_ack, 0);
    wait_tick_exact(e + 3);
    check("coin_ack_swap_tick", edit_ack, 0);
    @(negedge clk);
    check("coin_ack_after_swap", edit_ack, 1);
    settle_after(e + 3);
    f = tick_n;

    // Reset asserted mid-RUN, stray gen_done afterwards is ignored
    eng_lat = 100;
    expect_ev(EV_START, f + 1, 1'b1, 7);
    pulse_step();
    wait_tick_exact(f + 1);
    repeat (50) @(negedge clk);
    check("mid_run_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_disp_bank", disp_bank, 0);
    check("async_rst_gen_count", gen_count, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_gen_start", gen_start, 0);
    check("async_rst_edit_ack", edit_ack, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    settle_after(f + 3);
    check("post_rst_busy", busy, 0);
    check("post_rst_disp_bank", disp_bank, 0);
    check("post_rst_gen_count", gen_count, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
